// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned PC_W    = 32;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_STEP = 4;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] word;
        logic               filled;
    } fetch_entry_t;

    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
        return pc & ~PC_W'(3);
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// In-order prefetch queue: entries are allocated at grant and filled when the
// memory returns data; only the head entry is visible to decode.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               alloc,
    input  logic [PC_W-1:0]    alloc_pc,
    input  logic               fill,
    input  logic [INSTR_W-1:0] fill_word,
    input  logic               pop,
    output fetch_entry_t       head,
    output logic [CNT_W-1:0]   count,
    output logic [CNT_W-1:0]   unfilled
);

    fetch_entry_t     entries_q [DEPTH];
    fetch_entry_t     entries_d [DEPTH];
    logic [PTR_W-1:0] alloc_ptr_q, alloc_ptr_d;
    logic [PTR_W-1:0] fill_ptr_q, fill_ptr_d;
    logic [PTR_W-1:0] head_ptr_q, head_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] unfilled_q, unfilled_d;

    // Alloc and fill never target the same slot: alloc always lands on a free one.
    always_comb begin
        entries_d   = entries_q;
        alloc_ptr_d = alloc_ptr_q;
        fill_ptr_d  = fill_ptr_q;
        head_ptr_d  = head_ptr_q;
        count_d     = count_q;
        unfilled_d  = unfilled_q;
        if (flush) begin
            alloc_ptr_d = '0;
            fill_ptr_d  = '0;
            head_ptr_d  = '0;
            count_d     = '0;
            unfilled_d  = '0;
        end else begin
            if (alloc) begin
                entries_d[alloc_ptr_q].pc     = alloc_pc;
                entries_d[alloc_ptr_q].filled = 1'b0;
                alloc_ptr_d                   = alloc_ptr_q + PTR_W'(1);
            end
            if (fill) begin
                entries_d[fill_ptr_q].word   = fill_word;
                entries_d[fill_ptr_q].filled = 1'b1;
                fill_ptr_d                   = fill_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                head_ptr_d = head_ptr_q + PTR_W'(1);
            end
            count_d    = count_q + CNT_W'(alloc) - CNT_W'(pop);
            unfilled_d = unfilled_q + CNT_W'(alloc) - CNT_W'(fill);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            head_ptr_q  <= '0;
            count_q     <= '0;
            unfilled_q  <= '0;
        end else begin
            entries_q   <= entries_d;
            alloc_ptr_q <= alloc_ptr_d;
            fill_ptr_q  <= fill_ptr_d;
            head_ptr_q  <= head_ptr_d;
            count_q     <= count_d;
            unfilled_q  <= unfilled_d;
        end
    end

    always_comb begin
        head     = entries_q[head_ptr_q];
        count    = count_q;
        unfilled = unfilled_q;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: fetch PC, pipelined imem requests, prefetch queue
// and redirect handling with discard of responses still owed by memory.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned      DEPTH    = 4,
    parameter logic [PC_W-1:0]  RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               ins_valid,
    input  logic               ins_ready,
    output logic [INSTR_W-1:0] ins,
    output logic [PC_W-1:0]    ins_pc,
    output logic [PC_W-1:0]    ins_npc
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             run_q, run_d;
    logic [CNT_W-1:0] count, unfilled;
    logic [CNT_W:0]   owed;
    fetch_entry_t     head;
    logic             grant, fill, pop;

    // Issue, response steering and redirect bookkeeping; redirect overrides all.
    always_comb begin
        run_d      = 1'b1;
        fetch_pc_d = fetch_pc_q;
        drop_cnt_d = drop_cnt_q;
        imem_req   = run_q && (count < CNT_W'(DEPTH)) && !redirect_valid;
        imem_addr  = fetch_pc_q;
        grant      = imem_req && imem_gnt;
        fill       = imem_rvalid && (drop_cnt_q == '0) && (unfilled != '0) && !redirect_valid;
        ins_valid  = (count != '0) && head.filled;
        pop        = ins_valid && ins_ready && !redirect_valid;
        ins        = head.word;
        ins_pc     = head.pc;
        ins_npc    = head.pc + PC_W'(PC_STEP);
        owed       = {1'b0, drop_cnt_q} + {1'b0, unfilled};
        if (redirect_valid) begin
            fetch_pc_d = align_pc(redirect_pc);
            drop_cnt_d = CNT_W'(owed - (CNT_W + 1)'(imem_rvalid && (owed != '0)));
        end else begin
            if (grant) begin
                fetch_pc_d = fetch_pc_q + PC_W'(PC_STEP);
            end
            if (imem_rvalid && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q      <= 1'b0;
            fetch_pc_q <= RESET_PC;
            drop_cnt_q <= '0;
        end else begin
            run_q      <= run_d;
            fetch_pc_q <= fetch_pc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    fetch_buffer #(
        .DEPTH (DEPTH)
    ) u_buffer (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .alloc     (grant),
        .alloc_pc  (fetch_pc_q),
        .fill      (fill),
        .fill_word (imem_rdata),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .unfilled  (unfilled)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order instruction memory model.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        ins_valid;
    logic        ins_ready;
    logic [31:0] ins;
    logic [31:0] ins_pc;
    logic [31:0] ins_npc;

    logic        rv_w, rdy_w, gnt_en, hold, spur;
    logic [31:0] rpc_w;
    logic [31:0] pend [$];
    int          checks, errors, grants, n;

    fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .ins_valid      (ins_valid),
        .ins_ready      (ins_ready),
        .ins            (ins),
        .ins_pc         (ins_pc),
        .ins_npc        (ins_npc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // One cycle: apply inputs at negedge, record any grant once outputs settle.
    task automatic step();
        @(negedge clk);
        redirect_valid = rv_w;
        redirect_pc    = rpc_w;
        ins_ready      = rdy_w;
        imem_gnt       = gnt_en;
        if (!hold && pend.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = pend.pop_front() ^ 32'hA5A5_0000;
        end else if (spur) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
        #1;
        if (imem_req && imem_gnt) begin
            pend.push_back(imem_addr);
            grants++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst            = 1'b0;
        imem_rvalid    = 1'b0;
        imem_gnt       = 1'b0;
        redirect_valid = 1'b0;
        rv_w           = 1'b0;
        spur           = 1'b0;
        hold           = 1'b0;
        pend.delete();
        grants = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_valid(input int max_cyc, output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!ins_valid && cyc < max_cyc);
    endtask

    initial begin
        checks = 0; errors = 0; grants = 0;
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; ins_ready = 1'b0;
        rv_w = 1'b0; rpc_w = '0; rdy_w = 1'b0; gnt_en = 1'b0; hold = 1'b0; spur = 1'b0;
        #1 rst = 1'b0;
        #2;
        check("rst_req",   32'(imem_req), 0);
        check("rst_addr",  imem_addr, 32'h0);
        check("rst_valid", 32'(ins_valid), 0);
        check("rst_ins",   ins, 32'h0);
        check("rst_pc",    ins_pc, 32'h0);
        check("rst_npc",   ins_npc, 32'h4);

        // Streaming with a zero-wait memory
        do_reset(); gnt_en = 1'b1; rdy_w = 1'b1;
        step();
        check("st_req0",  32'(imem_req), 1);
        check("st_addr0", imem_addr, 32'h0);
        check("st_v0",    32'(ins_valid), 0);
        step();
        check("st_v1",    32'(ins_valid), 0);
        for (int i = 0; i < 8; i++) begin
            step();
            check("st_valid", 32'(ins_valid), 1);
            check("st_pc",    ins_pc, 32'(4 * i));
            check("st_ins",   ins, 32'(4 * i) ^ 32'hA5A5_0000);
            check("st_npc",   ins_npc, 32'(4 * i + 4));
        end

        // Back-pressure fills the queue, then the stall releases on the first pop
        do_reset(); gnt_en = 1'b1; rdy_w = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("bp_req",  32'(imem_req), 1);
            check("bp_addr", imem_addr, 32'(4 * i));
        end
        step();
        check("bp_stall", 32'(imem_req), 0);
        step();
        check("bp_grants", 32'(grants), 4);
        check("bp_head",   ins_pc, 32'h0);
        rdy_w = 1'b1;
        step();
        check("bp_req_pop", 32'(imem_req), 0);
        check("bp_pop_pc",  ins_pc, 32'h0);
        step();
        check("bp_req_again",  32'(imem_req), 1);
        check("bp_addr_again", imem_addr, 32'h10);
        for (int i = 1; i < 4; i++) begin
            check("bp_valid", 32'(ins_valid), 1);
            check("bp_pc",    ins_pc, 32'(4 * i));
            step();
        end

        // Redirect with three requests outstanding
        do_reset(); gnt_en = 1'b1; rdy_w = 1'b1; hold = 1'b1;
        step(); step(); step();
        rv_w = 1'b1; rpc_w = 32'h100;
        step();
        check("rd_req_off", 32'(imem_req), 0);
        rv_w = 1'b0; hold = 1'b0;
        step();
        check("rd_req",   32'(imem_req), 1);
        check("rd_addr",  imem_addr, 32'h100);
        check("rd_v",     32'(ins_valid), 0);
        wait_valid(12, n);
        check("rd_lat",   32'(n), 4);
        check("rd_pc",    ins_pc, 32'h100);
        check("rd_ins",   ins, 32'hA5A5_0100);

        // Redirect coinciding with a response and a would-be pop
        do_reset(); gnt_en = 1'b1; rdy_w = 1'b1;
        step();
        hold = 1'b1; step();
        hold = 1'b0; step();
        rv_w = 1'b1; rpc_w = 32'h200;
        step();
        check("sim_head_v",  32'(ins_valid), 1);
        check("sim_head_pc", ins_pc, 32'h0);
        rv_w = 1'b0;
        step();
        check("sim_v",    32'(ins_valid), 0);
        check("sim_addr", imem_addr, 32'h200);
        wait_valid(12, n);
        check("sim_lat",  32'(n), 2);
        check("sim_pc",   ins_pc, 32'h200);
        check("sim_ins",  ins, 32'hA5A5_0200);

        // Unaligned redirect target and PC wrap
        do_reset(); gnt_en = 1'b1; rdy_w = 1'b1;
        rv_w = 1'b1; rpc_w = 32'hFFFF_FFFE;
        step();
        rv_w = 1'b0;
        step();
        check("wr_addr0", imem_addr, 32'hFFFF_FFFC);
        step();
        check("wr_addr1", imem_addr, 32'h0);
        step();
        check("wr_pc",  ins_pc, 32'hFFFF_FFFC);
        check("wr_npc", ins_npc, 32'h0);
        check("wr_ins", ins, 32'h5A5A_FFFC);
        step();
        check("wr_pc1", ins_pc, 32'h0);

        // Stray response with nothing outstanding is ignored
        do_reset(); gnt_en = 1'b0; rdy_w = 1'b1; spur = 1'b1;
        step();
        spur = 1'b0; gnt_en = 1'b1;
        step();
        check("sp_v",   32'(ins_valid), 0);
        wait_valid(8, n);
        check("sp_lat", 32'(n), 2);
        check("sp_pc",  ins_pc, 32'h0);
        check("sp_ins", ins, 32'hA5A5_0000);

        // Asynchronous reset between clock edges
        do_reset(); gnt_en = 1'b1; rdy_w = 1'b1;
        step(); step(); step(); step();
        check("ar_pre_v", 32'(ins_valid), 1);
        #2 rst = 1'b0;
        #1;
        check("ar_req", 32'(imem_req), 0);
        check("ar_v",   32'(ins_valid), 0);
        check("ar_pc",  ins_pc, 32'h0);
        pend.delete();
        imem_rvalid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step();
        check("ar_req1",  32'(imem_req), 1);
        check("ar_addr1", imem_addr, 32'h0);
        step();
        step();
        check("ar_v2",  32'(ins_valid), 1);
        check("ar_pc2", ins_pc, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
